// File: rtl/gcd_pkg.sv
// Shared types and helpers for the binary (Stein) GCD engine.
package gcd_pkg;

  // Engine control states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REDUCE = 2'd2,
    DONE   = 2'd3
  } gcd_state_e;

  // Smallest counter width whose range exceeds the worst-case latency 3*width+2.
  function automatic int min_cnt_w(input int width);
    int w;
    w = 1;
    while ((64'd1 << w) <= 64'(3 * width + 2)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/gcd_stein_if.sv
// Operand/result valid-ready channel of the GCD engine.
interface gcd_stein_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cycles;

  // Producer/consumer side.
  modport master (
    output in_valid, opa, opb, out_ready,
    input  in_ready, out_valid, result, cycles
  );

  // Engine side.
  modport slave (
    input  in_valid, opa, opb, out_ready,
    output in_ready, out_valid, result, cycles
  );

endinterface

// File: rtl/gcd_stein_step.sv
// One binary-GCD reduction step: halve whichever operand is even, otherwise
// replace the larger one by half the difference. Purely combinational.
module gcd_stein_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic             zero
);

  // Apply the first matching reduction rule; the larger value is always the minuend.
  always_comb begin
    a_nxt = a;
    b_nxt = b;
    if (a[0] == 1'b0) begin
      a_nxt = a >> 1'b1;
    end else if (b[0] == 1'b0) begin
      b_nxt = b >> 1'b1;
    end else if (a >= b) begin
      a_nxt = (a - b) >> 1'b1;
    end else begin
      b_nxt = (b - a) >> 1'b1;
    end
  end

  assign zero = (a_nxt == '0);

endmodule

// File: rtl/gcd_stein.sv
// Binary GCD engine with valid/ready on both sides and a per-computation
// cycle counter. One reduction step per clock, one computation in flight.
module gcd_stein
  import gcd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input logic        clk,
  input logic        resetn,
  gcd_stein_if.slave bus
);

  localparam int K_W = $clog2(WIDTH);

  if (WIDTH < 2) begin : g_width_check
    $error("gcd_stein: WIDTH must be at least 2");
  end

  if (CNT_W < min_cnt_w(WIDTH)) begin : g_cnt_w_check
    $error("gcd_stein: CNT_W too small to hold the worst-case cycle count");
  end

  gcd_state_e       state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s, b_r, b_s;
  logic [K_W-1:0]   k_r, k_s;
  logic [CNT_W-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic [CNT_W-1:0] cycles_r, cycles_s;
  logic             in_ready_r, out_valid_r;
  logic [WIDTH-1:0] a_step_s, b_step_s;
  logic             zero_step_s;

  gcd_stein_step #(.WIDTH(WIDTH)) u_step (
    .a     (a_r),
    .b     (b_r),
    .a_nxt (a_step_s),
    .b_nxt (b_step_s),
    .zero  (zero_step_s)
  );

  // Saturating increment of the cycle counter.
  always_comb begin
    cnt_inc_s = cnt_r;
    if (cnt_r == {CNT_W{1'b1}}) begin
      cnt_inc_s = cnt_r;
    end else begin
      cnt_inc_s = cnt_r + CNT_W'(1);
    end
  end

  // Next-state and datapath update for each engine state.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    b_s      = b_r;
    k_s      = k_r;
    cnt_s    = cnt_r;
    result_s = result_r;
    cycles_s = cycles_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid && in_ready_r) begin
          a_s   = bus.opa;
          b_s   = bus.opb;
          k_s   = '0;
          cnt_s = CNT_W'(1);
          if ((bus.opa == '0) || (bus.opb == '0)) begin
            state_s  = DONE;
            result_s = bus.opa | bus.opb;
            cycles_s = CNT_W'(1);
          end else begin
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        cnt_s = cnt_inc_s;
        if ((a_r[0] == 1'b0) && (b_r[0] == 1'b0)) begin
          a_s = a_r >> 1'b1;
          b_s = b_r >> 1'b1;
          k_s = k_r + K_W'(1);
        end else begin
          state_s = REDUCE;
        end
      end
      REDUCE: begin
        cnt_s = cnt_inc_s;
        a_s   = a_step_s;
        b_s   = b_step_s;
        if (zero_step_s) begin
          state_s  = DONE;
          result_s = b_step_s << k_r;
          cycles_s = cnt_inc_s;
        end else begin
          state_s = REDUCE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_r         <= '0;
      b_r         <= '0;
      k_r         <= '0;
      cnt_r       <= '0;
      result_r    <= '0;
      cycles_r    <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      a_r         <= a_s;
      b_r         <= b_s;
      k_r         <= k_s;
      cnt_r       <= cnt_s;
      result_r    <= result_s;
      cycles_r    <= cycles_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.cycles    = cycles_r;

endmodule

// File: tb/tb_gcd_stein.sv
// Self-checking bench for gcd_stein: a WIDTH=32 engine, a WIDTH=8 engine and
// a standalone WIDTH=8 step datapath, with a queue-based scoreboard.
module tb_gcd_stein;

  logic   clk = 1'b0;
  logic   resetn = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc_now = 0;

  bit [31:0] exp_q[$];
  bit [7:0]  exp8_q[$];

  gcd_stein_if #(.WIDTH(32), .CNT_W(8)) bus32 ();
  gcd_stein_if #(.WIDTH(8),  .CNT_W(5)) bus8 ();

  gcd_stein #(.WIDTH(32), .CNT_W(8)) u_dut (.clk(clk), .resetn(resetn), .bus(bus32));
  gcd_stein #(.WIDTH(8),  .CNT_W(5)) u_dut8 (.clk(clk), .resetn(resetn), .bus(bus8));

  logic [7:0] sa, sb, sa_n, sb_n;
  logic       sz;
  gcd_stein_step #(.WIDTH(8)) u_step (.a(sa), .b(sb), .a_nxt(sa_n), .b_nxt(sb_n), .zero(sz));

  always #5 clk = ~clk;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  // Euclid by remainder, independent of the binary algorithm under test.
  function automatic longint unsigned gcd_ref(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic send32(input logic [31:0] a, input logic [31:0] b, output longint acc, output bit ok);
    bus32.opa = a;
    bus32.opb = b;
    bus32.in_valid = 1'b1;
    exp_q.push_back(32'(gcd_ref(64'(a), 64'(b))));
    ok = 1'b0;
    acc = 0;
    for (int n = 0; n < 400; n++) begin
      if (bus32.in_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc_now;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus32.in_valid = 1'b0;
  endtask

  task automatic recv32(input longint acc, input bit consume, output logic [31:0] res,
                        output logic [7:0] cyc, output int lat, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (bus32.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    lat = int'(cyc_now - acc);
    res = bus32.result;
    cyc = bus32.cycles;
    if (ok && consume) begin
      bus32.out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, output longint acc, output bit ok);
    bus8.opa = a;
    bus8.opb = b;
    bus8.in_valid = 1'b1;
    exp8_q.push_back(8'(gcd_ref(64'(a), 64'(b))));
    ok = 1'b0;
    acc = 0;
    for (int n = 0; n < 100; n++) begin
      if (bus8.in_ready === 1'b1) begin
        @(posedge clk); #1;
        acc = cyc_now;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
  endtask

  task automatic recv8(input longint acc, output logic [7:0] res, output logic [4:0] cyc,
                       output int lat, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (bus8.out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    lat = int'(cyc_now - acc);
    res = bus8.result;
    cyc = bus8.cycles;
    if (ok) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus32.in_ready !== 1'b0 || bus32.out_valid !== 1'b0 ||
        bus32.result !== 32'd0 || bus32.cycles !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b result=%0d cycles=%0d, required 0/0/0/0",
               bus32.in_ready, bus32.out_valid, bus32.result, bus32.cycles);
    end
    resetn = 1'b1;
    #1;
    n_cmp++;
    if (bus32.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready=%b before first clock, required 0", bus32.in_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus32.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle_ready: in_ready=%b after first clock, required 1", bus32.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] va[5] = '{32'd102, 32'd23040, 32'd51167, 32'd82066, 32'd93842};
    logic [31:0] vb[5] = '{32'd12,  32'd1944,  32'd266,   32'd36915, 32'd82082};
    logic [31:0] res, exp;
    logic [7:0]  cyc;
    longint      acc;
    int          lat;
    bit          ok_s, ok_r;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send32(va[i], vb[i], acc, ok_s);
      recv32(acc, 1'b1, res, cyc, lat, ok_r);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!ok_s || !ok_r || res !== exp) begin
        n_bad++;
        $display("FAIL basic_result[%0d]: got %0d (accept=%b done=%b), required %0d", i, res, ok_s, ok_r, exp);
      end
      n_cmp++;
      if (cyc > 8'd98 || int'(cyc) != lat + 1) begin
        n_bad++;
        $display("FAIL basic_cycles[%0d]: cycles=%0d latency=%0d, required cycles=latency+1 <= 98", i, cyc, lat);
      end
    end
  endtask

  task automatic test_zero_equal();
    logic [31:0] va[4] = '{32'd0, 32'd0, 32'd96, 32'h8000_0000};
    logic [31:0] vb[4] = '{32'd4660, 32'd0, 32'd96, 32'h8000_0000};
    logic [31:0] res, exp;
    logic [7:0]  cyc;
    longint      acc;
    int          lat;
    bit          ok_s, ok_r;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send32(va[i], vb[i], acc, ok_s);
      recv32(acc, 1'b1, res, cyc, lat, ok_r);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!ok_s || !ok_r || res !== exp) begin
        n_bad++;
        $display("FAIL zero_eq_result[%0d]: got %0d, required %0d", i, res, exp);
      end
      n_cmp++;
      if (int'(cyc) != lat + 1) begin
        n_bad++;
        $display("FAIL zero_eq_cycles[%0d]: cycles=%0d latency=%0d, required latency+1", i, cyc, lat);
      end
      if (i == 0) begin
        n_cmp++;
        if (lat != 0 || cyc !== 8'd1) begin
          n_bad++;
          $display("FAIL zero_latency: latency=%0d cycles=%0d, required 0 and 1", lat, cyc);
        end
      end
      n_cmp++;
      if (bus32.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_eq_drop[%0d]: out_valid=%b after handshake, required 0", i, bus32.out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res0, res, exp;
    logic [7:0]  cyc0, cyc;
    longint      acc;
    int          lat;
    bit          ok_s, ok_r;
    bus32.out_ready = 1'b0;
    send32(32'd23040, 32'd1944, acc, ok_s);
    recv32(acc, 1'b0, res0, cyc0, lat, ok_r);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok_s || !ok_r || res0 !== exp) begin
      n_bad++;
      $display("FAIL bp_first_result: got %0d, required %0d", res0, exp);
    end
    bus32.opa = 32'd68490;
    bus32.opb = 32'd78579;
    bus32.in_valid = 1'b1;
    exp_q.push_back(32'(gcd_ref(64'd68490, 64'd78579)));
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (bus32.out_valid !== 1'b1 || bus32.in_ready !== 1'b0 ||
          bus32.result !== res0 || bus32.cycles !== cyc0) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b result=%0d cycles=%0d, required 1/0/%0d/%0d",
                 i, bus32.out_valid, bus32.in_ready, bus32.result, bus32.cycles, res0, cyc0);
      end
    end
    bus32.out_ready = 1'b1;
    @(posedge clk); #1;
    bus32.out_ready = 1'b0;
    n_cmp++;
    if (bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0/1", bus32.out_valid, bus32.in_ready);
    end
    @(posedge clk); #1;
    acc = cyc_now;
    bus32.in_valid = 1'b0;
    n_cmp++;
    if (bus32.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_accept: in_ready=%b after accept, required 0", bus32.in_ready);
    end
    bus32.out_ready = 1'b1;
    recv32(acc, 1'b1, res, cyc, lat, ok_r);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok_r || res !== exp || int'(cyc) != lat + 1) begin
      n_bad++;
      $display("FAIL bp_second: result=%0d cycles=%0d latency=%0d, required %0d and latency+1", res, cyc, lat, exp);
    end
  endtask

  task automatic test_abort();
    logic [31:0] res, exp;
    logic [7:0]  cyc;
    longint      acc;
    int          lat;
    bit          ok_s, ok_r, seen;
    bus32.out_ready = 1'b1;
    send32(32'd65414, 32'd95995, acc, ok_s);
    repeat (4) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    n_cmp++;
    if (!ok_s || bus32.out_valid !== 1'b0 || bus32.in_ready !== 1'b0 ||
        bus32.result !== 32'd0 || bus32.cycles !== 8'd0) begin
      n_bad++;
      $display("FAIL abort_clear: out_valid=%b in_ready=%b result=%0d cycles=%0d, required all 0",
               bus32.out_valid, bus32.in_ready, bus32.result, bus32.cycles);
    end
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (bus32.out_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL abort_no_result: out_valid=1 seen after abort, required never");
    end
    send32(32'd35802, 32'd98620, acc, ok_s);
    recv32(acc, 1'b1, res, cyc, lat, ok_r);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!ok_s || !ok_r || res !== exp) begin
      n_bad++;
      $display("FAIL abort_next_result: got %0d, required %0d", res, exp);
    end
  endtask

  task automatic test_back_to_back_w8();
    logic [7:0] ca[9] = '{8'd0, 8'd255, 8'd128, 8'd255, 8'd1, 8'd128, 8'd0, 8'd254, 8'd192};
    logic [7:0] cb[9] = '{8'd0, 8'd255, 8'd128, 8'd1, 8'd255, 8'd192, 8'd255, 8'd255, 8'd128};
    logic [7:0] a, b, res, exp;
    logic [4:0] cyc;
    longint     acc;
    int         lat;
    bit         ok_s, ok_r;
    bus8.out_ready = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if (i < 9) begin
        a = ca[i];
        b = cb[i];
      end else begin
        a = 8'($urandom_range(0, 255));
        b = 8'($urandom_range(0, 255));
      end
      send8(a, b, acc, ok_s);
      recv8(acc, res, cyc, lat, ok_r);
      exp = exp8_q.pop_front();
      n_cmp++;
      if (!ok_s || !ok_r || res !== exp) begin
        n_bad++;
        $display("FAIL w8_result(%0d,%0d): got %0d, required %0d", a, b, res, exp);
      end
      n_cmp++;
      if (cyc > 5'd26 || int'(cyc) != lat + 1) begin
        n_bad++;
        $display("FAIL w8_cycles(%0d,%0d): cycles=%0d latency=%0d, required latency+1 <= 26", a, b, cyc, lat);
      end
    end
  endtask

  task automatic test_step_exhaustive();
    logic [7:0] ea, eb;
    logic       ez;
    for (int x = 0; x < 256; x++) begin
      for (int y = 0; y < 256; y++) begin
        sa = 8'(x);
        sb = 8'(y);
        #1;
        ea = sa;
        eb = sb;
        if (sa[0] == 1'b0) ea = sa >> 1;
        else if (sb[0] == 1'b0) eb = sb >> 1;
        else if (sa >= sb) ea = (sa - sb) >> 1;
        else eb = (sb - sa) >> 1;
        ez = (ea == 8'd0);
        n_cmp++;
        if (sa_n !== ea || sb_n !== eb || sz !== ez) begin
          n_bad++;
          $display("FAIL step(%0d,%0d): got a=%0d b=%0d z=%b, required a=%0d b=%0d z=%b",
                   x, y, sa_n, sb_n, sz, ea, eb, ez);
        end
      end
    end
  endtask

  initial begin
    bus32.in_valid = 1'b0;
    bus32.opa = 32'd0;
    bus32.opb = 32'd0;
    bus32.out_ready = 1'b1;
    bus8.in_valid = 1'b0;
    bus8.opa = 8'd0;
    bus8.opb = 8'd0;
    bus8.out_ready = 1'b1;
    sa = 8'd0;
    sb = 8'd0;
    test_reset();
    test_basic();
    test_zero_equal();
    test_backpressure();
    test_abort();
    test_back_to_back_w8();
    test_step_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
